// File: rtl/nanorv32_periph_apb_bridge.sv
// Arbiter peripheral port to APB4 bridge: one transfer at a time, wait states,
// slave-error passthrough and a forced completion when a slave never answers.
module nanorv32_periph_apb_bridge #(
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] periph_addr,
   input  logic [3:0]            periph_bytesel,
   input  logic [31:0]           periph_din,
   input  logic                  periph_en,
   output logic [31:0]           periph_dout,
   output logic                  periph_ready_nxt,
   output logic                  bus_err_r,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [31:0]           pwdata,
   output logic [3:0]            pstrb,
   input  logic [31:0]           prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int CW_RAW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW        = (CW_RAW > 8) ? CW_RAW : 8;
   localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [31:0]           r_pwdata;
   logic [3:0]            r_pstrb;
   logic [31:0]           r_dout;
   logic                  r_bus_err;

   logic                  w_timeout;
   logic                  w_done;

   // A slave that answers in the last allowed cycle still wins over the timeout.
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
   assign w_done    = (r_state == S_ACCESS) && (pready || w_timeout);

   assign periph_ready_nxt = w_done;
   assign periph_dout      = r_dout;
   assign bus_err_r        = r_bus_err;
   assign psel             = r_psel;
   assign penable          = r_penable;
   assign pwrite           = r_pwrite;
   assign paddr            = r_paddr;
   assign pwdata           = r_pwdata;
   assign pstrb            = r_pstrb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
         r_dout    <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (periph_en) begin
                  r_paddr  <= periph_addr;
                  r_pwrite <= |periph_bytesel;
                  r_pstrb  <= periph_bytesel;
                  r_pwdata <= (|periph_bytesel) ? periph_din : 32'h0;
                  r_psel   <= 1'b1;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready) begin
                  r_dout    <= r_pwrite ? 32'h0 : prdata;
                  r_bus_err <= pslverr;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_state   <= S_DONE;
               end else if (w_timeout) begin
                  r_dout    <= 32'h0;
                  r_bus_err <= 1'b1;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            // Bubble: the arbiter's ready_r cycle, where a stale request may still be up.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
